// File: rtl/pulse_regen_pkg.sv
// rtl/pulse_regen_pkg.sv - state encoding and width helpers shared by pulse_regen
package pulse_regen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Bits needed to hold every value 0..maxval, never less than one.
    function automatic int width_for(input int maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - saturating up/down counter holding the replay backlog
module sat_updown_cnt
    import pulse_regen_pkg::*;
#(
    parameter int MAX = 3,
    parameter int W   = width_for(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic at_max;
    logic at_zero;

    assign at_max  = (count == MAX_V);
    assign at_zero = (count == '0);

    // A simultaneous dec frees a slot, so an inc at the limit is not lost then.
    assign ovf = inc && at_max && !dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + W'(1);
        end else if (dec && !inc && !at_zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/pulse_regen.sv
// rtl/pulse_regen.sv - regenerates spaced level pulses from single-cycle triggers
module pulse_regen
    import pulse_regen_pkg::*;
#(
    parameter int HIGH_CYCLES = 3,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                trig,
    output logic                                level_out,
    output logic                                busy,
    output logic [width_for(PEND_MAX)-1:0]      pending,
    output logic                                overflow
);

    localparam int CW = width_for(max2(HIGH_CYCLES, GAP_CYCLES) - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;
    logic          busy_nxt;
    logic          final_gap;
    logic          pend_nz;
    logic          q_inc;
    logic          q_dec;
    logic          ovf_cond;

    assign final_gap = (state == GAP) && (cnt == GAP_LAST);
    assign pend_nz   = (pending != '0);

    // On the final gap cycle a trigger with an empty backlog starts the next
    // pulse directly; with a non-empty backlog it is queued behind the head.
    assign q_dec = final_gap && pend_nz;
    assign q_inc = trig && (state != IDLE) && !(final_gap && !pend_nz);

    sat_updown_cnt #(
        .MAX (PEND_MAX),
        .W   (width_for(PEND_MAX))
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .inc   (q_inc),
        .dec   (q_dec),
        .count (pending),
        .ovf   (ovf_cond)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
            busy      <= busy_nxt;
            overflow  <= ovf_cond;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (trig) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (cnt == HIGH_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            GAP: begin
                if (final_gap) begin
                    cnt_nxt   = '0;
                    state_nxt = (pend_nz || trig) ? HIGH : IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are the registered image of the next state, so they change on
    // the same edge as the state and never see trig combinationally.
    always_comb begin
        level_nxt = (state_nxt == HIGH);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule
